// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and defaults for the two-requester mux arbiter
package mux_arb_pkg;

  localparam int WIDTH_DEFAULT     = 2;
  localparam int MAX_GRANT_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GX   = 2'd1,
    GY   = 2'd2
  } arb_state_t;

  typedef enum logic {
    WIN_X = 1'b0,
    WIN_Y = 1'b1
  } winner_t;

endpackage

// File: rtl/mux_2bit_arbiter_if.sv
// rtl/mux_2bit_arbiter_if.sv - request/grant and data bundle between requesters and the arbiter
interface mux_2bit_arbiter_if #(
  parameter int WIDTH = mux_arb_pkg::WIDTH_DEFAULT
);

  logic             req_x;
  logic             req_y;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             gnt_x;
  logic             gnt_y;
  logic             s;
  logic [WIDTH-1:0] m;
  logic             m_valid;

  modport master (
    output req_x, req_y, x, y,
    input  gnt_x, gnt_y, s, m, m_valid
  );

  modport slave (
    input  req_x, req_y, x, y,
    output gnt_x, gnt_y, s, m, m_valid
  );

endinterface

// File: rtl/lab1_3_2.sv
// rtl/lab1_3_2.sv - 2-to-1 multiplexer, s=0 selects x, s=1 selects y
module lab1_3_2 #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             s,
  output logic [WIDTH-1:0] m
);

  assign m = s ? y : x;

endmodule

// File: rtl/mux_2bit_arbiter.sv
// rtl/mux_2bit_arbiter.sv - round-robin arbiter driving a registered 2-to-1 mux
// Optional grant-length limit enabled by defining MUX_ARB_TIMEOUT_EN.
module mux_2bit_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter int MAX_GRANT = MAX_GRANT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  mux_2bit_arbiter_if.slave bus
);

  if (WIDTH < 1 || MAX_GRANT < 1) begin : g_param_check
    $error("mux_2bit_arbiter: WIDTH and MAX_GRANT must be positive");
  end

  arb_state_t       state, state_nxt;
  winner_t          last_winner, last_winner_nxt;
  logic             s_q, s_nxt;
  logic [WIDTH-1:0] m_q;
  logic             m_valid_q;
  logic [WIDTH-1:0] mux_out;
  logic             timeout;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_GRANT + 1);
  logic [CNT_W-1:0] grant_cnt;

  // Counts edges spent in the current grant; timeout is raised during the MAX_GRANT-th cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_cnt <= '0;
    end else if (state_nxt != state) begin
      grant_cnt <= '0;
    end else if (state != IDLE && grant_cnt != CNT_W'(MAX_GRANT)) begin
      grant_cnt <= grant_cnt + 1'b1;
    end
  end

  assign timeout = (grant_cnt >= CNT_W'(MAX_GRANT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt       = state;
    last_winner_nxt = last_winner;
    s_nxt           = s_q;
    case (state)
      IDLE: begin
        if (bus.req_x && bus.req_y) begin
          state_nxt = (last_winner == WIN_Y) ? GX : GY;
        end else if (bus.req_x) begin
          state_nxt = GX;
        end else if (bus.req_y) begin
          state_nxt = GY;
        end
      end
      GX: begin
        if (!bus.req_x || (timeout && bus.req_y)) begin
          state_nxt = bus.req_y ? GY : IDLE;
        end
      end
      GY: begin
        if (!bus.req_y || (timeout && bus.req_x)) begin
          state_nxt = bus.req_x ? GX : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == GX) begin
      s_nxt = 1'b0;
      if (state != GX) last_winner_nxt = WIN_X;
    end else if (state_nxt == GY) begin
      s_nxt = 1'b1;
      if (state != GY) last_winner_nxt = WIN_Y;
    end
  end

  lab1_3_2 #(.WIDTH(WIDTH)) u_mux (
    .x (bus.x),
    .y (bus.y),
    .s (s_q),
    .m (mux_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_winner <= WIN_Y;
      s_q         <= 1'b0;
      m_q         <= '0;
      m_valid_q   <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_winner <= last_winner_nxt;
      s_q         <= s_nxt;
      m_valid_q   <= (state != IDLE);
      if (state != IDLE) m_q <= mux_out;
    end
  end

  assign bus.gnt_x   = (state == GX);
  assign bus.gnt_y   = (state == GY);
  assign bus.s       = s_q;
  assign bus.m       = m_q;
  assign bus.m_valid = m_valid_q;

endmodule

// File: tb/tb_mux_2bit_arbiter.sv
// tb/tb_mux_2bit_arbiter.sv - self-checking bench for mux_2bit_arbiter
module tb_mux_2bit_arbiter;

  localparam int MAXG = 4;
`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  mux_2bit_arbiter_if #(.WIDTH(2)) bus ();

  mux_2bit_arbiter #(.WIDTH(2), .MAX_GRANT(MAXG)) dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: owner 0=none 1=X 2=Y; glen = cycles the current owner has held the grant.
  int       own    = 0;
  int       last   = 2;
  int       glen   = 0;
  logic     exp_s  = 1'b0;
  logic [1:0] exp_m = 2'b00;
  logic     exp_mv = 1'b0;

  initial begin
    int  n;
    bit  mine, other, expired;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        own = 0; last = 2; glen = 0; exp_s = 1'b0; exp_m = 2'b00; exp_mv = 1'b0;
      end else begin
        exp_mv = (own != 0);
        if (own == 1) exp_m = bus.x;
        else if (own == 2) exp_m = bus.y;
        if (own == 0) begin
          if (bus.req_x && bus.req_y) n = (last == 2) ? 1 : 2;
          else if (bus.req_x) n = 1;
          else if (bus.req_y) n = 2;
          else n = 0;
        end else begin
          mine    = (own == 1) ? bus.req_x : bus.req_y;
          other   = (own == 1) ? bus.req_y : bus.req_x;
          expired = TMO && (glen >= MAXG);
          if (mine && !(expired && other)) n = own;
          else if (other) n = 3 - own;
          else n = 0;
        end
        if (n != own) begin
          glen = (n != 0) ? 1 : 0;
          if (n != 0) last = n;
        end else if (n != 0 && glen < 1000) begin
          glen++;
        end
        own = n;
        if (own == 1) exp_s = 1'b0;
        if (own == 2) exp_s = 1'b1;
      end
      chk("model_gnt_x", bus.gnt_x, (own == 1));
      chk("model_gnt_y", bus.gnt_y, (own == 2));
      chk("model_s", bus.s, exp_s);
      chk("model_m", bus.m, exp_m);
      chk("model_m_valid", bus.m_valid, exp_mv);
    end
  end

  initial begin
    int len;
    bit run;
    rst_n = 1'b0;
    bus.req_x = 1'b0; bus.req_y = 1'b0; bus.x = 2'b00; bus.y = 2'b00;
    #3;
    chk("reset_gnt_x", bus.gnt_x, 0);
    chk("reset_gnt_y", bus.gnt_y, 0);
    chk("reset_s", bus.s, 0);
    chk("reset_m", bus.m, 0);
    chk("reset_m_valid", bus.m_valid, 0);
    @(negedge clk) rst_n = 1'b1;

    // single request from X
    @(negedge clk) begin bus.req_x = 1'b1; bus.x = 2'b10; bus.y = 2'b01; end
    @(posedge clk); #2;
    chk("single_gnt_x", bus.gnt_x, 1);
    chk("single_s", bus.s, 0);
    @(posedge clk); #2;
    chk("single_m", bus.m, 2'b10);
    chk("single_m_valid", bus.m_valid, 1);

    // asynchronous reset in the middle of a GX grant
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_gnt_x", bus.gnt_x, 0);
    chk("async_s", bus.s, 0);
    chk("async_m", bus.m, 0);
    chk("async_m_valid", bus.m_valid, 0);
    bus.req_x = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #2;
    chk("post_reset_idle_x", bus.gnt_x, 0);
    chk("post_reset_idle_y", bus.gnt_y, 0);

    // tie after reset goes to X, then a gapless handover to Y
    @(negedge clk) begin bus.req_x = 1'b1; bus.req_y = 1'b1; bus.x = 2'b11; bus.y = 2'b01; end
    @(posedge clk); #2;
    chk("tie_gnt_x", bus.gnt_x, 1);
    chk("tie_gnt_y", bus.gnt_y, 0);
    @(negedge clk) bus.req_x = 1'b0;
    @(posedge clk); #2;
    chk("handover_gnt_y", bus.gnt_y, 1);
    chk("handover_gnt_x", bus.gnt_x, 0);
    chk("handover_s", bus.s, 1);
    @(posedge clk); #2;
    chk("handover_m", bus.m, 2'b01);

    // after a Y grant, a tie from IDLE goes to X
    @(negedge clk) bus.req_y = 1'b0;
    @(posedge clk); #2;
    chk("rr_idle", bus.gnt_y, 0);
    @(negedge clk) begin bus.req_x = 1'b1; bus.req_y = 1'b1; end
    @(posedge clk); #2;
    chk("rr_gnt_x", bus.gnt_x, 1);
    @(negedge clk) begin bus.req_x = 1'b0; bus.req_y = 1'b0; end
    repeat (2) @(posedge clk);

    // grant length with the other requester waiting
    @(negedge clk) bus.req_x = 1'b1;
    @(posedge clk); #2;
    len = bus.gnt_x ? 1 : 0;
    run = 1'b1;
    @(negedge clk) bus.req_y = 1'b1;
    repeat (11) begin
      @(posedge clk); #2;
      if (run && bus.gnt_x) begin
        len++;
      end else if (run) begin
        run = 1'b0;
        chk("timeout_handover_gy", bus.gnt_y, 1);
      end
    end
    chk("contended_grant_len", len, TMO ? MAXG : 12);
    @(negedge clk) begin bus.req_x = 1'b0; bus.req_y = 1'b0; end
    repeat (2) @(posedge clk);

    // uncontended grant never times out
    @(negedge clk) bus.req_x = 1'b1;
    len = 0;
    run = 1'b1;
    repeat (12) begin
      @(posedge clk); #2;
      if (run && bus.gnt_x) len++;
      else run = 1'b0;
    end
    chk("uncontended_grant_len", len, 12);
    @(negedge clk) bus.req_x = 1'b0;

    // randomized level-held requests
    repeat (400) begin
      @(negedge clk);
      if ($urandom_range(3) == 0) bus.req_x = ~bus.req_x;
      if ($urandom_range(3) == 0) bus.req_y = ~bus.req_y;
      if ($urandom_range(7) == 0) begin bus.req_x = 1'b0; bus.req_y = 1'b0; end
      bus.x = 2'($urandom);
      bus.y = 2'($urandom);
    end
    repeat (2) @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_2bit_arbiter.md
MUX_2BIT_ARBITER -- requirements
Module: mux_2bit_arbiter

Interface
REQ-001 Parameter: WIDTH, 2, data width of each requester and of m.
REQ-002 Parameter: MAX_GRANT, 4, grant-length limit in cycles; used only when MUX_ARB_TIMEOUT_EN is defined.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: reset_n  input  1  asynchronous active-low reset.
REQ-006 Port: req_x, req_y  input  1 each  requests from requester X and requester Y; level-held while the requester wants the mux.
REQ-007 Port: x, y  input  WIDTH each  requester data.
REQ-008 Port: gnt_x, gnt_y  output  1 each  registered grants; at most one asserted.
REQ-009 Port: s  output  1  mux select: 0 = x, 1 = y.
REQ-010 Port: m  output  WIDTH  registered mux output.
REQ-011 Port: m_valid  output  1  m holds granted data.

Function
REQ-012 The FSM SHALL have states IDLE, GX and GY; gnt_x=1 only in GX, gnt_y=1 only in GY, s=1 only in GY, s held in IDLE.
REQ-013 IDLE SHALL go to GX if only req_x=1, to GY if only req_y=1, stay IDLE if neither.
REQ-014 If both requests are high in IDLE, the non-last-winner SHALL be granted (round-robin); last_winner updates on every grant entry.
REQ-015 GX SHALL stay in GX while req_x=1; when req_x=0, go to GY if req_y=1, else IDLE. GY is symmetric.
REQ-016 A handover GX->GY or GY->GX SHALL take one edge with no IDLE cycle; s toggles on that edge.
REQ-017 Latency: request sampled at edge k -> gnt at edge k; m/m_valid at edge k+1.
REQ-018 m SHALL load x (state GX) or y (state GY) on each edge; m_valid SHALL equal the previous cycle's gnt_x|gnt_y.
REQ-019 In IDLE, m SHALL hold its last value and m_valid SHALL be 0 one edge after the grant drops.
REQ-020 Requests from a requester whose grant is already active SHALL not change its grant; the other request is queued by level only.
REQ-021 Simultaneous drop of both requests SHALL go to IDLE.

Reset
REQ-022 reset_n=0 SHALL, immediately and asynchronously, force IDLE, gnt_x=0, gnt_y=0, s=0, m=0, m_valid=0, last_winner=Y (X wins first tie), grant counter=0.
REQ-023 Reset asserted mid-grant SHALL abort the grant; after release, arbitration restarts from IDLE on the next edge.

Configuration
REQ-024 Macro MUX_ARB_TIMEOUT_EN: when defined, a grant counter SHALL count cycles in GX/GY, clear on state entry and, at MAX_GRANT cycles with the other request high, force a handover per REQ-016.
REQ-025 With MUX_ARB_TIMEOUT_EN defined and the other request low, the grant SHALL continue; the counter saturates at MAX_GRANT.
REQ-026 Without MUX_ARB_TIMEOUT_EN, no counter SHALL exist and grants last until the request drops.

Structure
REQ-027 Package mux_arb_pkg SHALL hold the state type (IDLE/GX/GY), the WIDTH default and the MAX_GRANT default.
REQ-028 The datapath SHALL instantiate the existing 2-bit 2-to-1 mux module lab1_3_2 (x, y, s -> m) as its only sub-module, with output registered in this block.

Verification
REQ-029 Reset: assert reset_n=0 mid-GX -> gnt_x, s, m, m_valid all 0 within the same time step; IDLE after release.
REQ-030 Single request: req_x=1, x=2'b10 -> gnt_x=1, s=0 next edge; m=2'b10 with m_valid=1 one edge later.
REQ-031 Tie: req_x=req_y=1 from IDLE after reset -> GX first; drop req_x -> GY on the next edge with no idle gap, s=1, m=y one edge later.
REQ-032 Round-robin: after a GY grant ends, both requests high from IDLE -> GX granted.
REQ-033 Timeout (macro on, MAX_GRANT=4): req_x, req_y held high -> forced switch to GY after 4 GX cycles; with req_y low -> GX held indefinitely.
REQ-034 Timeout off: same stimulus -> GX held until req_x drops.
